// File: rtl/elixirchip_es1_spu_op_mac_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : elixirchip_es1_spu_op_mac_multi                            |
// | Description : Multi-channel signed multiply-accumulate. A bank of        |
// |               NUM_CHANNELS accumulators shares one multiplier; each      |
// |               valid input updates the selected accumulator, and the      |
// |               updated value is shifted/rounded/saturated onto m_data     |
// |               after a fixed LATENCY of enabled cycles.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module elixirchip_es1_spu_op_mac_multi #(
  parameter int       LATENCY      = 3,
  parameter int       NUM_CHANNELS = 4,
  parameter int       S_DATA0_BITS = 8,
  parameter int       S_DATA1_BITS = 9,
  parameter int       ACC_BITS     = 32,
  parameter int       M_DATA_BITS  = 16,
  parameter int       SHIFT        = 0,
  parameter bit       ROUNDING     = 1'b0,
  parameter bit       SATURATE     = 1'b0,
  parameter           DEVICE       = "RTL",
  parameter           SIMULATION   = "false",
  parameter           DEBUG        = "false",
  localparam int      CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cke,
  input  logic [CH_BITS-1:0]             s_ch,
  input  logic                           s_set,
  input  logic                           s_sub,
  input  logic signed [S_DATA0_BITS-1:0] s_data0,
  input  logic signed [S_DATA1_BITS-1:0] s_data1,
  input  logic                           s_valid,
  output logic [CH_BITS-1:0]             m_ch,
  output logic signed [M_DATA_BITS-1:0]  m_data,
  output logic                           m_valid
);

  localparam int c_P_BITS = S_DATA0_BITS + S_DATA1_BITS;
  localparam int c_DLY    = (LATENCY > 3) ? LATENCY - 3 : 1;
  // Scaling runs one bit wider than the accumulator (rounding never wraps),
  // plus headroom so the saturation bounds are representable.
  localparam int c_WIDE   = ((ACC_BITS + 1 > M_DATA_BITS) ? ACC_BITS + 1 : M_DATA_BITS) + 1;

  localparam logic [CH_BITS:0]            c_NUM_CH  = (CH_BITS + 1)'(NUM_CHANNELS);
  localparam logic signed [c_WIDE-1:0]    c_SAT_MAX = {{(c_WIDE - M_DATA_BITS + 1){1'b0}},
                                                       {(M_DATA_BITS - 1){1'b1}}};
  localparam logic signed [c_WIDE-1:0]    c_SAT_MIN = ~c_SAT_MAX;
  localparam logic signed [c_WIDE-1:0]    c_RND     = (ROUNDING && SHIFT > 0)
                                                      ? c_WIDE'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)
                                                      : '0;

  // Stage 1: registered inputs
  logic                           s1_valid_q, s1_valid_d;
  logic [CH_BITS-1:0]             s1_ch_q, s1_ch_d;
  logic                           s1_set_q, s1_set_d;
  logic                           s1_sub_q, s1_sub_d;
  logic signed [S_DATA0_BITS-1:0] s1_d0_q, s1_d0_d;
  logic signed [S_DATA1_BITS-1:0] s1_d1_q, s1_d1_d;

  // Stage 2: product
  logic                           s2_valid_q, s2_valid_d;
  logic [CH_BITS-1:0]             s2_ch_q, s2_ch_d;
  logic                           s2_set_q, s2_set_d;
  logic                           s2_sub_q, s2_sub_d;
  logic signed [c_P_BITS-1:0]     s2_prod_q, s2_prod_d;

  // Accumulator bank
  logic signed [ACC_BITS-1:0]     acc_q [NUM_CHANNELS];
  logic signed [ACC_BITS-1:0]     acc_d [NUM_CHANNELS];

  // Output register
  logic                           m_valid_q, m_valid_d;
  logic [CH_BITS-1:0]             m_ch_q, m_ch_d;
  logic signed [M_DATA_BITS-1:0]  m_data_q, m_data_d;

  logic                           w_ch_ok;
  logic signed [ACC_BITS-1:0]     w_prod_ext;
  logic signed [ACC_BITS-1:0]     w_acc_cur;
  logic signed [ACC_BITS-1:0]     w_acc_new;
  logic                           w_tail_valid;
  logic [CH_BITS-1:0]             w_tail_ch;
  logic signed [ACC_BITS-1:0]     w_tail_acc;
  logic signed [c_WIDE-1:0]       w_wide;
  logic signed [c_WIDE-1:0]       w_shift;
  logic signed [c_WIDE-1:0]       w_sat;

  // Out-of-range channels are dropped at the door so they never touch the bank.
  assign w_ch_ok = ({1'b0, s_ch} < c_NUM_CH);

  // Read-modify-write of the selected accumulator; the bank is flops, so the
  // read always sees the previous cycle's write and no forwarding is needed.
  always_comb begin
    w_prod_ext = ACC_BITS'(s2_prod_q);
    w_acc_cur  = acc_q[s2_ch_q];
    if (s2_set_q) begin
      w_acc_new = w_prod_ext;
    end else if (s2_sub_q) begin
      w_acc_new = w_acc_cur - w_prod_ext;
    end else begin
      w_acc_new = w_acc_cur + w_prod_ext;
    end
  end

  // Optional delay between the RMW stage and the output stage.
  if (LATENCY > 3) begin : g_dly
    logic                       dly_valid_q [c_DLY];
    logic                       dly_valid_d [c_DLY];
    logic [CH_BITS-1:0]         dly_ch_q    [c_DLY];
    logic [CH_BITS-1:0]         dly_ch_d    [c_DLY];
    logic signed [ACC_BITS-1:0] dly_acc_q   [c_DLY];
    logic signed [ACC_BITS-1:0] dly_acc_d   [c_DLY];

    // Shift the updated accumulator value down the delay line on enabled cycles.
    always_comb begin
      dly_valid_d = dly_valid_q;
      dly_ch_d    = dly_ch_q;
      dly_acc_d   = dly_acc_q;
      if (cke) begin
        dly_valid_d[0] = s2_valid_q;
        dly_ch_d[0]    = s2_ch_q;
        dly_acc_d[0]   = w_acc_new;
        for (int i = 1; i < c_DLY; i++) begin
          dly_valid_d[i] = dly_valid_q[i-1];
          dly_ch_d[i]    = dly_ch_q[i-1];
          dly_acc_d[i]   = dly_acc_q[i-1];
        end
      end
    end

    // Delay-line registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < c_DLY; i++) begin
          dly_valid_q[i] <= 1'b0;
          dly_ch_q[i]    <= '0;
          dly_acc_q[i]   <= '0;
        end
      end else begin
        dly_valid_q <= dly_valid_d;
        dly_ch_q    <= dly_ch_d;
        dly_acc_q   <= dly_acc_d;
      end
    end

    assign w_tail_valid = dly_valid_q[c_DLY-1];
    assign w_tail_ch    = dly_ch_q[c_DLY-1];
    assign w_tail_acc   = dly_acc_q[c_DLY-1];
  end else begin : g_nodly
    assign w_tail_valid = s2_valid_q;
    assign w_tail_ch    = s2_ch_q;
    assign w_tail_acc   = w_acc_new;
  end

  // Post-scaling: round half-up, arithmetic shift, then clamp or truncate.
  always_comb begin
    w_wide  = c_WIDE'(w_tail_acc) + c_RND;
    w_shift = w_wide >>> SHIFT;
    w_sat   = w_shift;
    if (SATURATE) begin
      if (w_shift > c_SAT_MAX) begin
        w_sat = c_SAT_MAX;
      end else if (w_shift < c_SAT_MIN) begin
        w_sat = c_SAT_MIN;
      end
    end
  end

  // Next-state for all pipeline stages, the bank and the output; cke=0 holds everything.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ch_d    = s1_ch_q;
    s1_set_d   = s1_set_q;
    s1_sub_d   = s1_sub_q;
    s1_d0_d    = s1_d0_q;
    s1_d1_d    = s1_d1_q;
    s2_valid_d = s2_valid_q;
    s2_ch_d    = s2_ch_q;
    s2_set_d   = s2_set_q;
    s2_sub_d   = s2_sub_q;
    s2_prod_d  = s2_prod_q;
    acc_d      = acc_q;
    m_valid_d  = m_valid_q;
    m_ch_d     = m_ch_q;
    m_data_d   = m_data_q;
    if (cke) begin
      s1_valid_d = s_valid && w_ch_ok;
      s1_ch_d    = s_ch;
      s1_set_d   = s_set;
      s1_sub_d   = s_sub;
      s1_d0_d    = s_data0;
      s1_d1_d    = s_data1;
      s2_valid_d = s1_valid_q;
      s2_ch_d    = s1_ch_q;
      s2_set_d   = s1_set_q;
      s2_sub_d   = s1_sub_q;
      s2_prod_d  = c_P_BITS'(s1_d0_q) * c_P_BITS'(s1_d1_q);
      if (s2_valid_q) begin
        acc_d[s2_ch_q] = w_acc_new;
      end
      m_valid_d = w_tail_valid;
      if (w_tail_valid) begin
        m_ch_d   = w_tail_ch;
        m_data_d = w_sat[M_DATA_BITS-1:0];
      end
    end
  end

  // State registers; synchronous reset clears the bank and flushes the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_set_q   <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_d0_q    <= '0;
      s1_d1_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_set_q   <= 1'b0;
      s2_sub_q   <= 1'b0;
      s2_prod_q  <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
      m_valid_q  <= 1'b0;
      m_ch_q     <= '0;
      m_data_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ch_q    <= s1_ch_d;
      s1_set_q   <= s1_set_d;
      s1_sub_q   <= s1_sub_d;
      s1_d0_q    <= s1_d0_d;
      s1_d1_q    <= s1_d1_d;
      s2_valid_q <= s2_valid_d;
      s2_ch_q    <= s2_ch_d;
      s2_set_q   <= s2_set_d;
      s2_sub_q   <= s2_sub_d;
      s2_prod_q  <= s2_prod_d;
      acc_q      <= acc_d;
      m_valid_q  <= m_valid_d;
      m_ch_q     <= m_ch_d;
      m_data_q   <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_ch    = m_ch_q;
  assign m_data  = m_data_q;

  // Behavioural-model builds carry the protocol checks.
  if (DEVICE == "RTL" || SIMULATION == "true" || DEBUG == "true") begin : g_assert
    logic [LATENCY-1:0] chk_hist_q, chk_hist_d;

    // History of s_valid over the last LATENCY enabled edges.
    always_comb begin
      chk_hist_d = chk_hist_q;
      if (cke) begin
        chk_hist_d = {chk_hist_q[LATENCY-2:0], s_valid};
      end
    end

    // History register, cleared with the pipeline.
    always_ff @(posedge clk) begin
      if (reset) begin
        chk_hist_q <= '0;
      end else begin
        chk_hist_q <= chk_hist_d;
      end
    end

    a_no_spurious_valid : assert property (@(posedge clk) disable iff (reset)
      m_valid |-> chk_hist_q[LATENCY-1]);

    a_sat_in_range : assert property (@(posedge clk) disable iff (reset)
      !SATURATE || (w_sat >= c_SAT_MIN && w_sat <= c_SAT_MAX));
  end

endmodule
`default_nettype wire

// File: tb/tb_elixirchip_es1_spu_op_mac_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_elixirchip_es1_spu_op_mac_multi                         |
// | Description : Scoreboard bench for the multi-channel MAC. Three DUT      |
// |               configurations share one stimulus stream; a reference      |
// |               model predicts each output and its due cycle.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_elixirchip_es1_spu_op_mac_multi;

  logic              clk = 1'b0;
  logic              reset;
  logic              cke;
  logic [1:0]        s_ch;
  logic              s_set;
  logic              s_sub;
  logic signed [7:0] s_data0;
  logic signed [8:0] s_data1;
  logic              s_valid;

  logic [1:0] ch_a, ch_b, ch_c;
  logic [9:0] d_a, d_b, d_c;
  logic       v_a, v_b, v_c;

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] data;
    int         due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   acc_m [4];
  logic [9:0] last_d [3];
  logic [1:0] last_c [3];

  always #5 clk = ~clk;

  // A: LATENCY 3, plain truncation
  elixirchip_es1_spu_op_mac_multi #(
    .LATENCY(3), .NUM_CHANNELS(4), .S_DATA0_BITS(8), .S_DATA1_BITS(9), .ACC_BITS(16),
    .M_DATA_BITS(10), .SHIFT(0), .ROUNDING(1'b0), .SATURATE(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .cke(cke), .s_ch(s_ch), .s_set(s_set), .s_sub(s_sub),
    .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
    .m_ch(ch_a), .m_data(d_a), .m_valid(v_a)
  );

  // B: LATENCY 4, shift 2 with rounding, saturation
  elixirchip_es1_spu_op_mac_multi #(
    .LATENCY(4), .NUM_CHANNELS(4), .S_DATA0_BITS(8), .S_DATA1_BITS(9), .ACC_BITS(16),
    .M_DATA_BITS(10), .SHIFT(2), .ROUNDING(1'b1), .SATURATE(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .cke(cke), .s_ch(s_ch), .s_set(s_set), .s_sub(s_sub),
    .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
    .m_ch(ch_b), .m_data(d_b), .m_valid(v_b)
  );

  // C: LATENCY 5, three channels (ch3 dropped), shift 2 without rounding, truncation
  elixirchip_es1_spu_op_mac_multi #(
    .LATENCY(5), .NUM_CHANNELS(3), .S_DATA0_BITS(8), .S_DATA1_BITS(9), .ACC_BITS(16),
    .M_DATA_BITS(10), .SHIFT(2), .ROUNDING(1'b0), .SATURATE(1'b0)
  ) dut_c (
    .clk(clk), .reset(reset), .cke(cke), .s_ch(s_ch), .s_set(s_set), .s_sub(s_sub),
    .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
    .m_ch(ch_c), .m_data(d_c), .m_valid(v_c)
  );

  function automatic int cfg_lat(int k);
    case (k) 0: return 3; 1: return 4; default: return 5; endcase
  endfunction
  function automatic int cfg_shift(int k);
    return (k == 0) ? 0 : 2;
  endfunction
  function automatic bit cfg_rnd(int k);
    return (k == 1);
  endfunction
  function automatic bit cfg_sat(int k);
    return (k == 1);
  endfunction
  function automatic int cfg_nch(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  // 16-bit two's-complement wrap of the accumulator
  function automatic int wrap_acc(int x);
    logic signed [15:0] t;
    t = x[15:0];
    return t;
  endfunction

  // Output scaling from the arithmetic definition
  function automatic logic [9:0] scale(int acc, int sh, bit rnd, bit sat);
    int r;
    r = acc;
    if (rnd && sh > 0) r = r + (1 << (sh - 1));
    r = r >>> sh;
    if (sat) begin
      if (r > 511) r = 511;
      else if (r < -512) r = -512;
    end
    return r[9:0];
  endfunction

  function automatic void push(int k, exp_t e);
    case (k) 0: q0.push_back(e); 1: q1.push_back(e); default: q2.push_back(e); endcase
  endfunction
  function automatic int qsize(int k);
    case (k) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
  endfunction
  function automatic exp_t qfront(int k);
    case (k) 0: return q0[0]; 1: return q1[0]; default: return q2[0]; endcase
  endfunction
  function automatic exp_t qpop(int k);
    case (k) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
  endfunction
  function automatic logic [12:0] get_out(int k);
    case (k)
      0: return {v_a, ch_a, d_a};
      1: return {v_b, ch_b, d_b};
      default: return {v_c, ch_c, d_c};
    endcase
  endfunction

  // Reference model: tracks the accumulators and predicts each DUT's outputs.
  initial begin : model
    int p, a;
    exp_t e;
    for (int i = 0; i < 4; i++) acc_m[i] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 4; i++) acc_m[i] = 0;
        q0.delete(); q1.delete(); q2.delete();
      end else if (cke) begin
        edge_cnt++;
        if (s_valid) begin
          p = int'(s_data0) * int'(s_data1);
          if (s_set) a = p;
          else if (s_sub) a = acc_m[s_ch] - p;
          else a = acc_m[s_ch] + p;
          acc_m[s_ch] = wrap_acc(a);
          for (int k = 0; k < 3; k++) begin
            if (int'(s_ch) < cfg_nch(k)) begin
              e.ch   = s_ch;
              e.data = scale(acc_m[s_ch], cfg_shift(k), cfg_rnd(k), cfg_sat(k));
              e.due  = edge_cnt + cfg_lat(k) - 1;
              push(k, e);
            end
          end
        end
      end
    end
  end

  // Monitor: compares each DUT's output against its queue on the falling edge.
  initial begin : monitor
    logic rl, el;
    logic [12:0] o;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      last_d[k] = '0;
      last_c[k] = '0;
    end
    forever begin
      @(posedge clk);
      rl = reset;
      el = cke && !reset;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        o = get_out(k);
        if (rl) begin
          vectors++;
          if (o !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_state dut%0d: got v=%0b ch=%0d data=%0d, required all zero",
                     k, o[12], o[11:10], $signed(o[9:0]));
          end
          last_d[k] = '0;
          last_c[k] = '0;
        end else if (qsize(k) > 0 && qfront(k).due == edge_cnt) begin
          e = qpop(k);
          vectors++;
          if (o[12] !== 1'b1 || o[11:10] !== e.ch || o[9:0] !== e.data) begin
            miscompares++;
            $display("FAIL output dut%0d edge %0d: got v=%0b ch=%0d data=%0d, required v=1 ch=%0d data=%0d",
                     k, edge_cnt, o[12], o[11:10], $signed(o[9:0]), e.ch, $signed(e.data));
          end
          last_d[k] = e.data;
          last_c[k] = e.ch;
        end else begin
          vectors++;
          if ((el && o[12] !== 1'b0) || o[11:10] !== last_c[k] || o[9:0] !== last_d[k]) begin
            miscompares++;
            $display("FAIL idle_hold dut%0d edge %0d: got v=%0b ch=%0d data=%0d, required v=0 ch=%0d data=%0d",
                     k, edge_cnt, o[12], o[11:10], $signed(o[9:0]), last_c[k], $signed(last_d[k]));
          end
        end
      end
    end
  end

  task automatic issue(input int ch, input bit set, input bit sub, input int d0, input int d1);
    cke = 1'b1; s_valid = 1'b1;
    s_ch = 2'(ch); s_set = set; s_sub = sub;
    s_data0 = 8'(d0); s_data1 = 9'(d1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cke = 1'b1; s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // cke low with garbage valid inputs that must be ignored
  task automatic hold(input int n);
    cke = 1'b0; s_valid = 1'b1; s_set = 1'b0; s_sub = 1'b0;
    s_data0 = 8'($urandom); s_data1 = 9'($urandom);
    repeat (n) @(negedge clk);
    cke = 1'b1; s_valid = 1'b0;
  endtask

  task automatic rst_pulse();
    reset = 1'b1; cke = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0;
  endtask

  // Stimulus: directed scenarios followed by random traffic.
  initial begin : stim
    reset = 1'b1; cke = 1'b1; s_valid = 1'b0; s_ch = '0;
    s_set = 1'b0; s_sub = 1'b0; s_data0 = '0; s_data1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // interleaved channels
    issue(0, 1, 0, 2, 3);
    issue(1, 1, 0, 5, 5);
    issue(0, 0, 0, 3, 4);
    issue(1, 0, 1, 1, 5);
    issue(0, 0, 0, -2, 3);
    idle(2);
    // same-channel burst
    issue(2, 1, 0, 0, 0);
    repeat (4) issue(2, 0, 0, 1, 1);
    idle(1);
    // burst with clock-enable hold and a bubble
    issue(1, 1, 0, 1, 1);
    issue(1, 0, 0, 1, 1);
    hold(2);
    issue(1, 0, 0, 1, 1);
    idle(1);
    issue(1, 0, 0, 1, 1);
    idle(3);
    // saturation and wrap
    issue(3, 1, 0, 100, 100);
    issue(3, 1, 0, -100, 100);
    issue(3, 1, 0, 127, 255);
    issue(3, 0, 0, 127, 255);
    // rounding around shift
    issue(0, 1, 0, 2, 3);
    issue(0, 1, 0, 5, 1);
    issue(0, 1, 0, -2, 3);
    idle(2);
    // reset with inputs in flight
    issue(0, 1, 0, 7, 7);
    issue(0, 0, 0, 3, 3);
    rst_pulse();
    issue(0, 0, 0, 1, 1);
    idle(6);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 200 == 0) begin
        rst_pulse();
      end else begin
        cke     = ($urandom % 8) != 0;
        s_valid = ($urandom % 4) != 0;
        s_ch    = 2'($urandom % 4);
        s_set   = ($urandom % 6) == 0;
        s_sub   = ($urandom % 2) == 0;
        s_data0 = 8'($urandom);
        s_data1 = 9'($urandom);
        @(negedge clk);
      end
    end

    idle(10);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (qsize(k) != 0) begin
        miscompares++;
        $display("FAIL drain dut%0d: got %0d outputs still pending, required 0", k, qsize(k));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
